// File: rtl/fsm6_pkg.sv
// Shared constants for the 10110 serial detector: state codes, pattern, counter width.
// Optional counter is enabled with macro FSM6_DET_COUNT_EN.
package fsm6_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_e;

    localparam logic [4:0] PATTERN = 5'b10110;
    localparam int         PAT_LEN = 5;

    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Only the full-match state flags a detection; illegal codes never do.
    function automatic logic is_detect(input state_e s);
        return (s == S5);
    endfunction

endpackage

// File: rtl/fsm6_next_state.sv
// Combinational next-state function for the 10110 detector (prefix-tracking, overlap-aware).
// Zero latency; no flow control.
module fsm6_next_state
    import fsm6_pkg::*;
(
    input  state_e state_i,
    input  logic   seq_i,
    output state_e next_o
);

    always_comb begin
        next_o = S0;
        case (state_i)
            S0: next_o = seq_i ? S1 : S0;
            S1: next_o = seq_i ? S1 : S2;
            S2: next_o = seq_i ? S3 : S0;
            S3: next_o = seq_i ? S4 : S2;
            S4: next_o = seq_i ? S1 : S5;
            // Trailing "10" of a match plus a new 1 is already "101".
            S5: next_o = seq_i ? S3 : S0;
            default: next_o = S0;
        endcase
    end

endmodule

// File: rtl/fsm6_seq_detector.sv
// Moore detector for serial pattern 10110; dout is high for each cycle spent in S5.
// Macro FSM6_DET_COUNT_EN adds a saturating 8-bit match counter (det_count).
module fsm6_seq_detector
    import fsm6_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             seq,
    output logic             dout
`ifdef FSM6_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] det_count
`endif
);

    state_e state_q;
    state_e state_d;

    fsm6_next_state u_next_state (
        .state_i (state_q),
        .seq_i   (seq),
        .next_o  (state_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Decoded from the state register only, so seq has no path to dout.
    assign dout = is_detect(state_q);

`ifdef FSM6_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (is_detect(state_d) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign det_count = cnt_q;
`endif

endmodule

// File: tb/tb_fsm6_seq_detector.sv
// Bench for fsm6_seq_detector: a last-five-bits history model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_fsm6_seq_detector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic seq = 1'b0;
    logic dout;
`ifdef FSM6_DET_COUNT_EN
    logic [7:0] det_count;
`endif

    fsm6_seq_detector dut (
        .clk       (clk),
        .rst       (rst),
        .seq       (seq),
        .dout      (dout)
`ifdef FSM6_DET_COUNT_EN
        ,
        .det_count (det_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: bits sampled since reset (capped at 5) and the last five of them.
    logic [4:0] m_hist;
    int         m_nbits;
    int         m_cnt;
    int         pulses;
    logic       chk_en = 1'b0;

    function automatic logic m_match();
        return (m_nbits >= 5) && (m_hist == 5'b10110);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist  = 5'b0;
        m_nbits = 0;
        m_cnt   = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dout_vs_model", {31'b0, dout}, {31'b0, rst && m_match()});
`ifdef FSM6_DET_COUNT_EN
            check("count_vs_model", {24'b0, det_count}, m_cnt);
`endif
        end
    end

    // Drive one bit, let the edge sample it, advance the model, return at the next negedge.
    task automatic step(input logic b);
        seq = b;
        @(posedge clk);
        if (rst) begin
            m_hist = {m_hist[3:0], b};
            if (m_nbits < 5) m_nbits++;
            if (m_match() && m_cnt < 255) m_cnt++;
        end
        #1;
        if (dout) pulses++;
        @(negedge clk);
    endtask

    task automatic run_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i]);
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic reset_mid();
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("async_rst_dout", {31'b0, dout}, 32'd0);
        check("async_rst_state", 32'(dut.state_q), 32'd0);
`ifdef FSM6_DET_COUNT_EN
        check("async_rst_count", {24'b0, det_count}, 32'd0);
`endif
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        pulses = 0;
    endtask

    initial begin
        model_reset();
        pulses = 0;
        rst    = 1'b0;
        seq    = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_dout", {31'b0, dout}, 32'd0);
        check("reset_state", 32'(dut.state_q), 32'd0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Reset from S3, then ones must not fire
        run_bits(32'b101, 3);
        check("reach_s3", 32'(dut.state_q), 32'd3);
        reset_mid();
        run_bits(32'b1111, 4);
        check("ones_after_rst_pulses", pulses, 32'd0);
        check("ones_after_rst_state", 32'(dut.state_q), 32'd1);

        // Basic match
        reset_mid();
        run_bits(32'b1011, 4);
        check("basic_before", {31'b0, dout}, 32'd0);
        step(1'b0);
        check("basic_hit", {31'b0, dout}, 32'd1);
        step(1'b0);
        check("basic_after", {31'b0, dout}, 32'd0);
        check("basic_pulses", pulses, 32'd1);

        // Overlap
        reset_mid();
        run_bits(32'b10110110, 8);
        check("overlap_pulses", pulses, 32'd2);
        check("overlap_last_hit", {31'b0, dout}, 32'd1);
`ifdef FSM6_DET_COUNT_EN
        check("overlap_count", {24'b0, det_count}, 32'd2);
`endif

        // Near misses
        reset_mid();
        run_bits(32'b1010110, 7);
        check("near_1010110_pulses", pulses, 32'd1);
        check("near_1010110_hit", {31'b0, dout}, 32'd1);
        reset_mid();
        run_bits(32'b101110, 6);
        check("near_101110_pulses", pulses, 32'd0);

        // Idle then all ones
        reset_mid();
        repeat (20) step(1'b0);
        check("idle_state", 32'(dut.state_q), 32'd0);
        repeat (20) step(1'b1);
        check("all_ones_state", 32'(dut.state_q), 32'd1);
        check("idle_ones_pulses", pulses, 32'd0);

        // Saturation: 10110 then 110 x300 gives 301 matches
        reset_mid();
        run_bits(32'b10110, 5);
        for (int k = 0; k < 300; k++) run_bits(32'b110, 3);
        check("sat_pulses", pulses, 32'd301);
`ifdef FSM6_DET_COUNT_EN
        check("sat_count", {24'b0, det_count}, 32'd255);
`endif
        reset_mid();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
